ofdm_cp_engine: RTL and testbench
=================================

Name: ofdm_cp_engine

Overview:
- Parametrised cyclic-prefix engine for the OFDM chain.
- In INSERT mode it sits after the IFFT. It buffers each NFFT-sample symbol and emits CP_LEN+NFFT samples: the last CP_LEN samples first, then the whole symbol.
- In REMOVE mode it sits before the FFT. It strips the first CP_LEN samples of each received block.
- It uses a ping-pong buffer with valid/ready handshakes on both sides, and runs entirely on clk_half.

Parameters:
- DW, 16, width of each of the re/im sample components (signed).
- NFFT, 64, samples per OFDM symbol; must be a power of 2, from 8 to 1024.
- CP_LEN, 16, cyclic-prefix length; legal range 1 to NFFT-1.

Ports:
- clk_half  in  1  block clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- mode_remove  in  1  0 = INSERT, 1 = REMOVE; sampled only when the engine is idle.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input accept; a transfer happens when in_valid && in_ready.
- in_sop  in  1  marks the first sample of an input symbol/block.
- in_re  in  DW  input real part.
- in_im  in  DW  input imaginary part.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accept.
- out_re  out  DW  output real part.
- out_im  out  DW  output imaginary part.
- out_sop  out  1  first output sample of a symbol.
- out_eop  out  1  last output sample of a symbol.
- sym_err  out  1  one-cycle pulse when a misaligned in_sop is seen.
- mode_active  out  1  the currently latched mode.

Behaviour:

Reset and general rules:
- Reset values: out_valid=0, out_re=0, out_im=0, out_sop=0, out_eop=0, sym_err=0, mode_active=0. Write/read counters=0, both bank-full flags=0, reader state=IDLE.
- in_ready is combinational from state and equals 1 immediately after reset deasserts.
- Asserting reset mid-operation discards all buffered data and any partially output symbol; no further out_valid appears until new input arrives.
- Output handshake: out_* registers are held stable while out_valid && !out_ready.
- Idle means both banks empty, reader IDLE and write counter 0.
- mode_remove is latched into mode_active only at idle. A change at any other time is ignored until the engine next reaches idle.

INSERT mode (mode_active=0):
- Writer:
  - Two banks of NFFT entries, each holding {re, im}.
  - wcnt counts 0..NFFT-1 into bank wb.
  - in_ready = !full[wb].
  - On the accepted sample with wcnt=NFFT-1: set full[wb], toggle wb, clear wcnt.
- in_sop rules:
  - in_sop accepted with wcnt!=0: pulse sym_err, discard the partial bank, and write the sample at index 0.
  - in_sop=0 with wcnt=0 is accepted as a start without error, so free-running streams work.
- Reader FSM states: IDLE, CP, BODY.
  - IDLE -> CP when full[rb]=1; rcnt=0.
  - CP: output bank[rb][NFFT-CP_LEN+rcnt]. out_sop=1 on rcnt=0. After CP_LEN accepted beats go to BODY with rcnt=0.
  - BODY: output bank[rb][rcnt]. out_eop=1 on rcnt=NFFT-1. On that beat's acceptance clear full[rb] and toggle rb.
  - After BODY: go to CP if the other bank is full (back-to-back, no bubble), else IDLE.
- A new output beat loads when !out_valid || out_ready.
- Latency: the first out_valid appears 1 cycle after the write of sample NFFT-1.
- Simultaneous write-complete and read-release on the same bank in the same cycle is legal: the clear and set apply to different banks by construction.
- Steady-state throughput with out_ready=1: NFFT inputs per CP_LEN+NFFT cycles. in_ready deasserts when both banks are full.

REMOVE mode (mode_active=1):
- Streaming only; the buffer is unused.
- Counter c runs over 0..CP_LEN+NFFT-1 per block. in_sop realigns c to 0, and pulses sym_err if c!=0.
- in_ready = !out_valid || out_ready.
- Samples with c<CP_LEN are accepted and dropped.
- Samples with c>=CP_LEN are registered to the output with 1-cycle latency. out_sop=1 at c=CP_LEN and out_eop=1 at c=CP_LEN+NFFT-1.
- c wraps to 0 after CP_LEN+NFFT-1.

Arithmetic and widths:
- Samples pass through unmodified; there is no scaling or saturation.
- Counters are $clog2(NFFT+CP_LEN) bits wide.

Test Plan (all with NFFT=64, CP_LEN=16):
- INSERT single symbol, in_re=k, in_im=-k for k=0..63, out_ready=1 -> 80 beats: re=48..63 then 0..63; out_sop on beat 0, out_eop on beat 79; first out_valid 1 cycle after the k=63 write.
- INSERT with continuous in_valid over 4 symbols -> 320 contiguous out_valid beats with no gaps; in_ready drops to 0 while both banks are full; no samples lost or duplicated.
- INSERT with random out_ready (50%) -> out_* stable while stalled; output sequence identical to the out_ready=1 run.
- in_sop injected at wcnt=20 -> sym_err pulses for 1 cycle; the next 80 output beats start from the re-aligned symbol (re=48 of the new data).
- REMOVE mode with an 80-sample block, in_re=0..79 -> 64 outputs re=16..79, out_sop at re=16, out_eop at re=79, 1-cycle latency; mode_remove toggled mid-block has no effect until idle.
- Reset asserted at output beat 30 -> all outputs return to 0 asynchronously; after release, in_ready=1 and a fresh symbol produces a correct 80-beat burst.

Source files
------------

// File: rtl/ofdm_cp_engine.sv
// Cyclic-prefix engine: INSERT buffers whole symbols in a ping-pong RAM and replays
// the tail as prefix; REMOVE streams blocks through and drops the leading prefix.
module ofdm_cp_engine #(
    parameter int DW     = 16,
    parameter int NFFT   = 64,
    parameter int CP_LEN = 16
) (
    input  logic          clk_half,
    input  logic          reset,
    input  logic          mode_remove,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sop,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_re,
    output logic [DW-1:0] out_im,
    output logic          out_sop,
    output logic          out_eop,
    output logic          sym_err,
    output logic          mode_active
);

    localparam int CW = $clog2(NFFT + CP_LEN);
    localparam int AW = $clog2(NFFT);
    localparam logic [CW-1:0] ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] LAST_W   = CW'(NFFT - 1);
    localparam logic [CW-1:0] LAST_CP  = CW'(CP_LEN - 1);
    localparam logic [CW-1:0] CP_C     = CW'(CP_LEN);
    localparam logic [CW-1:0] LAST_BLK = CW'(CP_LEN + NFFT - 1);
    localparam logic [CW-1:0] CP_BASE  = CW'(NFFT - CP_LEN);

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CP   = 2'd1,
        RD_BODY = 2'd2
    } rd_state_t;

    rd_state_t         rd_state_r, rd_next_s;
    logic              mode_r, wb_r, rb_r, rb_next_s;
    logic [1:0]        full_r;
    logic [CW-1:0]     wcnt_r, wcnt_next_s, rcnt_r, rcnt_next_s, c_eff_s;
    logic [2*DW-1:0]   mem_r [0:2*NFFT-1];
    logic [2*DW-1:0]   rd_word_s;
    logic [AW-1:0]     rd_idx_s, wr_idx_s;
    logic              load_s, in_ready_s, accept_s, complete_s, misalign_s, keep_s, idle_s;
    logic              emit_s, emit_sop_s, emit_eop_s, release_s;
    logic              out_valid_r, out_sop_r, out_eop_r, sym_err_r;
    logic [DW-1:0]     out_re_r, out_im_r;

    // Input side: acceptance, sop realignment and the write / block counter (c in REMOVE)
    always_comb begin
        load_s     = !out_valid_r || out_ready;
        if (mode_r) begin
            in_ready_s = load_s;
        end else begin
            in_ready_s = !full_r[wb_r];
        end
        accept_s = in_valid && in_ready_s;
        if (in_sop) begin
            c_eff_s = ZERO;
        end else begin
            c_eff_s = wcnt_r;
        end
        wr_idx_s    = AW'(c_eff_s);
        misalign_s  = accept_s && in_sop && (wcnt_r != ZERO);
        complete_s  = 1'b0;
        wcnt_next_s = wcnt_r;
        if (accept_s) begin
            if (mode_r) begin
                if (c_eff_s == LAST_BLK) begin
                    wcnt_next_s = ZERO;
                end else begin
                    wcnt_next_s = c_eff_s + ONE;
                end
            end else if (c_eff_s == LAST_W) begin
                wcnt_next_s = ZERO;
                complete_s  = 1'b1;
            end else begin
                wcnt_next_s = c_eff_s + ONE;
            end
        end else begin
            wcnt_next_s = wcnt_r;
        end
        keep_s = accept_s && (c_eff_s >= CP_C);
        idle_s = (full_r == 2'b00) && (rd_state_r == RD_IDLE) && (wcnt_r == ZERO);
    end

    // Reader FSM next state; IDLE behaves like CP beat 0 so the first beat needs no extra cycle
    always_comb begin
        rd_next_s   = rd_state_r;
        rcnt_next_s = rcnt_r;
        rb_next_s   = rb_r;
        release_s   = 1'b0;
        emit_s      = 1'b0;
        emit_sop_s  = 1'b0;
        emit_eop_s  = 1'b0;
        rd_idx_s    = AW'(rcnt_r);
        if (!mode_r && load_s) begin
            case (rd_state_r)
                RD_IDLE, RD_CP: begin
                    if ((rd_state_r == RD_CP) || full_r[rb_r]) begin
                        emit_s     = 1'b1;
                        emit_sop_s = (rcnt_r == ZERO);
                        rd_idx_s   = AW'(CP_BASE + rcnt_r);
                        if (rcnt_r == LAST_CP) begin
                            rd_next_s   = RD_BODY;
                            rcnt_next_s = ZERO;
                        end else begin
                            rd_next_s   = RD_CP;
                            rcnt_next_s = rcnt_r + ONE;
                        end
                    end else begin
                        rd_next_s = rd_state_r;
                    end
                end
                RD_BODY: begin
                    emit_s = 1'b1;
                    if (rcnt_r == LAST_W) begin
                        emit_eop_s  = 1'b1;
                        release_s   = 1'b1;
                        rb_next_s   = ~rb_r;
                        rcnt_next_s = ZERO;
                        rd_next_s   = full_r[~rb_r] ? RD_CP : RD_IDLE;
                    end else begin
                        rcnt_next_s = rcnt_r + ONE;
                    end
                end
                default: begin
                    rd_next_s   = RD_IDLE;
                    rcnt_next_s = ZERO;
                end
            endcase
        end else begin
            rd_next_s = rd_state_r;
        end
        rd_word_s = mem_r[{rb_r, rd_idx_s}];
    end

    // Control state: counters, bank pointers, full flags and the idle-only mode latch
    always_ff @(posedge clk_half or posedge reset) begin
        if (reset) begin
            rd_state_r <= RD_IDLE;
            wcnt_r     <= ZERO;
            rcnt_r     <= ZERO;
            wb_r       <= 1'b0;
            rb_r       <= 1'b0;
            full_r     <= 2'b00;
            mode_r     <= 1'b0;
            sym_err_r  <= 1'b0;
        end else begin
            rd_state_r <= rd_next_s;
            wcnt_r     <= wcnt_next_s;
            rcnt_r     <= rcnt_next_s;
            rb_r       <= rb_next_s;
            sym_err_r  <= misalign_s;
            if (complete_s) begin
                wb_r           <= ~wb_r;
                full_r[wb_r]   <= 1'b1;
            end
            if (release_s) begin
                full_r[rb_r]   <= 1'b0;
            end
            if (idle_s && !accept_s) begin
                mode_r <= mode_remove;
            end
        end
    end

    // Symbol storage, written only in INSERT mode
    always_ff @(posedge clk_half) begin
        if (accept_s && !mode_r) begin
            mem_r[{wb_r, wr_idx_s}] <= {in_re, in_im};
        end
    end

    // Output register: loads a new beat whenever the current one is empty or taken
    always_ff @(posedge clk_half or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_re_r    <= {DW{1'b0}};
            out_im_r    <= {DW{1'b0}};
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
        end else if (load_s) begin
            if (mode_r) begin
                out_valid_r <= keep_s;
                out_sop_r   <= keep_s && (c_eff_s == CP_C);
                out_eop_r   <= keep_s && (c_eff_s == LAST_BLK);
                if (keep_s) begin
                    out_re_r <= in_re;
                    out_im_r <= in_im;
                end
            end else begin
                out_valid_r <= emit_s;
                out_sop_r   <= emit_sop_s;
                out_eop_r   <= emit_eop_s;
                if (emit_s) begin
                    out_re_r <= rd_word_s[2*DW-1:DW];
                    out_im_r <= rd_word_s[DW-1:0];
                end
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign out_re      = out_re_r;
    assign out_im      = out_im_r;
    assign out_sop     = out_sop_r;
    assign out_eop     = out_eop_r;
    assign sym_err     = sym_err_r;
    assign mode_active = mode_r;

endmodule

// File: tb/tb_ofdm_cp_engine.sv
// Scoreboard bench for ofdm_cp_engine: a symbol-level reference model queues expected
// beats as inputs are accepted; an independent monitor pops and compares.
module tb_ofdm_cp_engine;

    localparam int DW   = 16;
    localparam int NFFT = 64;
    localparam int CP   = 16;

    logic          clk_half = 1'b0;
    logic          reset = 1'b1;
    logic          mode_remove = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] in_re = 16'd0;
    logic [DW-1:0] in_im = 16'd0;
    logic          in_ready, out_valid, out_sop, out_eop, sym_err, mode_active;
    logic [DW-1:0] out_re, out_im;

    ofdm_cp_engine #(.DW(DW), .NFFT(NFFT), .CP_LEN(CP)) dut (
        .clk_half(clk_half), .reset(reset), .mode_remove(mode_remove),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .out_sop(out_sop), .out_eop(out_eop),
        .sym_err(sym_err), .mode_active(mode_active)
    );

    initial forever #5 clk_half = ~clk_half;

    int          n_tests = 0, n_fail = 0, cyc = 0;
    longint      exp_q[$];
    logic [15:0] part_re[$], part_im[$];
    int          rm_pos = 0, exp_err = 0, err_seen = 0;
    int          beat_cnt = 0, first_cyc = 0, last_cyc = 0, wr_edge = 0;
    bit          model_mode = 1'b0, rand_ready = 1'b0, saw_not_ready = 1'b0, stalled = 1'b0;
    longint      held = 0, cur = 0;

    initial forever begin
        @(posedge clk_half);
        cyc++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint pack(input logic [15:0] re, input logic [15:0] im,
                                    input logic s, input logic e);
        return longint'({re, im, s, e});
    endfunction

    // Reference: INSERT emits tail-then-whole of each complete symbol; REMOVE drops the first CP of each block
    task automatic model_accept(input logic [15:0] re, input logic [15:0] im, input logic sop);
        if (!model_mode) begin
            if (sop && part_re.size() != 0) begin
                exp_err++;
                part_re.delete();
                part_im.delete();
            end
            part_re.push_back(re);
            part_im.push_back(im);
            if (part_re.size() == NFFT) begin
                for (int i = 0; i < CP + NFFT; i++) begin
                    int j;
                    j = (i < CP) ? (NFFT - CP + i) : (i - CP);
                    exp_q.push_back(pack(part_re[j], part_im[j], i == 0, i == CP + NFFT - 1));
                end
                part_re.delete();
                part_im.delete();
            end
        end else begin
            if (sop) begin
                if (rm_pos != 0) exp_err++;
                rm_pos = 0;
            end
            if (rm_pos >= CP) exp_q.push_back(pack(re, im, rm_pos == CP, rm_pos == CP + NFFT - 1));
            rm_pos = (rm_pos + 1) % (CP + NFFT);
        end
    endtask

    task automatic send(input logic [15:0] re, input logic [15:0] im, input logic sop);
        int guard;
        @(negedge clk_half);
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        in_sop   = sop;
        #1;
        guard = 0;
        while (!in_ready && guard < 1000) begin
            @(negedge clk_half);
            #1;
            guard++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        else model_accept(re, im, sop);
        wr_edge = cyc + 1;
    endtask

    task automatic idle_in();
        @(negedge clk_half);
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(negedge clk_half);
            g++;
        end
        check(name, exp_q.size(), 0);
        repeat (4) @(negedge clk_half);
    endtask

    task automatic send_symbol(input bit first_sop);
        for (int k = 0; k < NFFT; k++)
            send(16'($urandom), 16'($urandom), first_sop && (k == 0));
    endtask

    initial forever begin
        @(negedge clk_half);
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability
    initial forever begin
        @(negedge clk_half);
        #1;
        cur = longint'({out_valid, out_re, out_im, out_sop, out_eop});
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) check("stall_hold", cur, held);
            if (!in_ready) saw_not_ready = 1'b1;
            if (sym_err) err_seen++;
            if (out_valid && out_ready) begin
                if (beat_cnt == 0) first_cyc = cyc;
                last_cyc = cyc;
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none", cur);
                end else begin
                    check("beat", pack(out_re, out_im, out_sop, out_eop), exp_q.pop_front());
                end
            end
            stalled = out_valid && !out_ready;
            held    = cur;
        end
    end

    initial begin
        int w63, w16, err_base, g;
        repeat (2) @(negedge clk_half);
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", {out_re, out_im}, 0);
        check("rst_sop_eop", {out_sop, out_eop}, 0);
        check("rst_sym_err", sym_err, 0);
        check("rst_mode", mode_active, 0);
        check("rst_in_ready", in_ready, 1);

        // INSERT single ramp symbol
        beat_cnt = 0;
        for (int k = 0; k < NFFT; k++) send(16'(k), 16'(-k), k == 0);
        w63 = wr_edge;
        idle_in();
        drain("ins_single_drain");
        check("ins_single_beats", beat_cnt, 80);
        check("ins_latency", first_cyc, w63 + 1);

        // Four back-to-back free-running symbols
        beat_cnt = 0;
        saw_not_ready = 1'b0;
        for (int s = 0; s < 4; s++) send_symbol(1'b0);
        idle_in();
        drain("ins_burst_drain");
        check("ins_burst_beats", beat_cnt, 320);
        check("ins_burst_span", last_cyc - first_cyc + 1, 320);
        check("ins_burst_backpressure", saw_not_ready, 1);

        // Random downstream stalls
        beat_cnt = 0;
        rand_ready = 1'b1;
        for (int s = 0; s < 3; s++) send_symbol(s == 0);
        idle_in();
        drain("ins_stall_drain");
        rand_ready = 1'b0;
        check("ins_stall_beats", beat_cnt, 240);

        // Misaligned in_sop at wcnt=20
        beat_cnt = 0;
        err_base = err_seen;
        for (int k = 0; k < 20; k++) send(16'($urandom), 16'($urandom), k == 0);
        send_symbol(1'b1);
        idle_in();
        drain("sop_realign_drain");
        check("sop_err_pulses", err_seen - err_base, 1);
        check("sop_realign_beats", beat_cnt, 80);

        // REMOVE mode, mode toggle mid-block ignored until idle
        mode_remove = 1'b1;
        repeat (3) @(negedge clk_half);
        #1;
        check("rm_mode_latched", mode_active, 1);
        model_mode = 1'b1;
        rm_pos = 0;
        beat_cnt = 0;
        for (int i = 0; i < CP + NFFT; i++) begin
            if (i == 40) mode_remove = 1'b0;
            send(16'(i), 16'(i * 3 + 7), i == 0);
            if (i == 16) w16 = wr_edge;
            if (i == 60) check("rm_mode_hold", mode_active, 1);
        end
        idle_in();
        drain("rm_drain");
        check("rm_beats", beat_cnt, 64);
        check("rm_latency", first_cyc, w16);
        check("rm_mode_release", mode_active, 0);
        model_mode = 1'b0;

        // Asynchronous reset in the middle of an output burst
        beat_cnt = 0;
        send_symbol(1'b1);
        idle_in();
        g = 0;
        while (beat_cnt < 30 && g < 500) begin
            @(negedge clk_half);
            #2;
            g++;
        end
        check("rst_mid_reached", beat_cnt >= 30, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_outputs", {out_valid, out_re, out_im, out_sop, out_eop, sym_err}, 0);
        exp_q.delete();
        part_re.delete();
        part_im.delete();
        @(negedge clk_half);
        reset = 1'b0;
        #1;
        check("rst_mid_in_ready", in_ready, 1);
        repeat (5) @(negedge clk_half);
        #1;
        check("rst_mid_quiet", out_valid, 0);
        beat_cnt = 0;
        send_symbol(1'b1);
        idle_in();
        drain("rst_fresh_drain");
        check("rst_fresh_beats", beat_cnt, 80);

        check("sym_err_total", err_seen, exp_err);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
